// File: rtl/sint7_run_detector_pkg.sv
// Shared definitions for the signed-sample run detector: FSM encoding and
// default widths.
package sint7_run_detector_pkg;

    localparam int unsigned DEF_WIDTH     = 7;
    localparam int unsigned DEF_THRESHOLD = 3;
    localparam int unsigned DEF_CNT_WIDTH = 4;
    localparam int unsigned DEF_SEQ_WIDTH = 8;

    // 2'd3 is unused and recovers to ST_UNARMED.
    typedef enum logic [1:0] {
        ST_UNARMED = 2'd0,
        ST_ARMED   = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

endpackage : sint7_run_detector_pkg

// File: rtl/sint_eq_cmp.sv
// Combinational equality compare of two two's-complement operands.
// Ports:
//   in0, in1 : operands (WIDTH bits)
//   out      : 1 when all WIDTH bits are equal
module sint_eq_cmp
    import sint7_run_detector_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out
);

    // Bitwise equality; sign interpretation does not change the result.
    assign out = (in0 == in1);

endmodule : sint_eq_cmp

// File: rtl/sint7_run_detector.sv
// Counts consecutive accepted samples equal to a programmable reference and
// emits one registered report (sequence index of the completing sample) when
// the run reaches THRESHOLD.
// Ports:
//   CLK, RESET         : clock, synchronous active-high reset
//   ref_load/ref_value : load new reference (arms the detector)
//   I_valid/I_data     : sample input; I_ready is combinational from state
//   O_valid/O_seq      : registered report output, held until O_ready
module sint7_run_detector
    import sint7_run_detector_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned THRESHOLD = DEF_THRESHOLD,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int unsigned SEQ_WIDTH = DEF_SEQ_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ref_load,
    input  logic [WIDTH-1:0]     ref_value,
    input  logic                 I_valid,
    input  logic [WIDTH-1:0]     I_data,
    output logic                 I_ready,
    output logic                 O_valid,
    output logic [SEQ_WIDTH-1:0] O_seq,
    input  logic                 O_ready
);

    // Run count value at which the next match completes a run.
    localparam logic [CNT_WIDTH-1:0] RUN_LAST = CNT_WIDTH'(THRESHOLD - 1);

    state_t               state_q,   state_d;
    logic [WIDTH-1:0]     ref_q,     ref_d;
    logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
    logic [SEQ_WIDTH-1:0] seq_q,     seq_d;
    logic                 o_valid_d;
    logic [SEQ_WIDTH-1:0] o_seq_d;
    logic                 match;
    logic                 accept;

    sint_eq_cmp #(
        .WIDTH (WIDTH)
    ) u_eq_cmp (
        .in0 (I_data),
        .in1 (ref_q),
        .out (match)
    );

    assign I_ready = (state_q == ST_UNARMED) || (state_q == ST_ARMED);
    assign accept  = I_valid && I_ready;

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_UNARMED;
            ref_q     <= '0;
            run_cnt_q <= '0;
            seq_q     <= '0;
            O_valid   <= 1'b0;
            O_seq     <= '0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            run_cnt_q <= run_cnt_d;
            seq_q     <= seq_d;
            O_valid   <= o_valid_d;
            O_seq     <= o_seq_d;
        end
    end

    // Next-state and next-output logic; ref_load beats samples and O_ready.
    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        run_cnt_d = run_cnt_q;
        seq_d     = seq_q;
        o_valid_d = O_valid;
        o_seq_d   = O_seq;

        if (ref_load) begin
            ref_d     = ref_value;
            run_cnt_d = '0;
            state_d   = ST_ARMED;
            o_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_UNARMED: begin
                    // Samples are drained and discarded until armed.
                end
                ST_ARMED: begin
                    if (accept) begin
                        seq_d = seq_q + SEQ_WIDTH'(1);
                        if (match && (run_cnt_q == RUN_LAST)) begin
                            o_seq_d   = seq_q;
                            o_valid_d = 1'b1;
                            run_cnt_d = '0;
                            state_d   = ST_REPORT;
                        end else if (match) begin
                            run_cnt_d = run_cnt_q + CNT_WIDTH'(1);
                        end else begin
                            run_cnt_d = '0;
                        end
                    end
                end
                ST_REPORT: begin
                    if (O_valid && O_ready) begin
                        o_valid_d = 1'b0;
                        state_d   = ST_ARMED;
                    end
                end
                default: begin
                    state_d   = ST_UNARMED;
                    run_cnt_d = '0;
                    o_valid_d = 1'b0;
                end
            endcase
        end
    end

endmodule : sint7_run_detector
